// File: rtl/inst_queue_fifo.sv
// ---------------------------------------------------------------------------
// inst_queue_fifo
//
// Instruction queue sitting between instruction fetch and decode. Holds up to
// DEPTH {instruction, pc, predicted-taken} entries in a circular buffer with
// valid/ready handshakes on both sides. The read side is first-word-fall-
// through: the head entry is presented combinationally from storage.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   rdy          global enable; 0 freezes all state and blocks transfers
//   clear        synchronous flush on branch misprediction
//   in_valid     fetch offers an entry
//   in_inst      instruction to enqueue
//   in_pc        pc of that instruction
//   in_pred      predicted-taken bit of that instruction
//   in_ready     queue can accept an entry this cycle
//   out_valid    head entry available
//   out_inst     head instruction (0 when out_valid = 0)
//   out_pc       head pc (0 when out_valid = 0)
//   out_pred     head predicted-taken (0 when out_valid = 0)
//   out_ready    decode takes the head entry
//   count        current occupancy, 0..DEPTH
//   almost_full  free entries <= AF_MARGIN
// ---------------------------------------------------------------------------
module inst_queue_fifo #(
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [INST_W-1:0]        in_inst,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic                     in_pred,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [INST_W-1:0]        out_inst,
    output logic [ADDR_W-1:0]        out_pc,
    output logic                     out_pred,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INST_W + ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);

    // Entry layout: {pred, pc, inst}
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake qualifiers. A full queue refuses pushes even if a pop happens
    // in the same cycle, so out_ready never reaches in_ready.
    assign in_ready  = rdy & ~clear & (count != FULL_COUNT);
    assign out_valid = rdy & ~clear & (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head data falls through from storage and is zeroed when not valid.
    assign head_entry = mem[head];
    assign out_inst   = out_valid ? head_entry[INST_W-1:0] : '0;
    assign out_pc     = out_valid ? head_entry[INST_W +: ADDR_W] : '0;
    assign out_pred   = out_valid ? head_entry[ENTRY_W-1] : 1'b0;

    assign almost_full = (count >= AF_LEVEL);

    // Storage write: memory is deliberately not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {in_pred, in_pc, in_inst};
        end
    end

    // Pointer and occupancy registers. A flush (only honoured while rdy is
    // high) wins over any push or pop; otherwise the pointers advance on
    // their own handshake and count moves only when exactly one side fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy && clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_queue_fifo.sv
// ---------------------------------------------------------------------------
// tb_inst_queue_fifo
//
// Directed bench for inst_queue_fifo configured with DEPTH = 4 and
// AF_MARGIN = 1. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
// Each instruction word is derived from its pc so entries are traceable.
// ---------------------------------------------------------------------------
module tb_inst_queue_fifo;

    localparam int INST_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 1;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              clear;
    logic              in_valid;
    logic [INST_W-1:0] in_inst;
    logic [ADDR_W-1:0] in_pc;
    logic              in_pred;
    logic              in_ready;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_pred;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              almost_full;

    int assertCount;
    int failCount;

    inst_queue_fifo #(
        .INST_W    (INST_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_pred     (in_pred),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pred    (out_pred),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction word associated with a pc.
    function automatic logic [INST_W-1:0] instOf(input logic [ADDR_W-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Predicted-taken bit associated with a pc.
    function automatic logic predOf(input logic [ADDR_W-1:0] pc);
        return pc[2];
    endfunction

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive handshake inputs for the coming cycle and let them settle.
    task automatic applyStimulus(input logic vld, input logic [ADDR_W-1:0] pc,
                                 input logic ordy);
        in_valid  = vld;
        in_pc     = pc;
        in_inst   = instOf(pc);
        in_pred   = predOf(pc);
        out_ready = ordy;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full head entry against a pc.
    task automatic checkHead(input string tag, input logic [ADDR_W-1:0] pc);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_pc"},    64'(out_pc),    64'(pc));
        checkOutput({tag, "_inst"},  64'(out_inst),  64'(instOf(pc)));
        checkOutput({tag, "_pred"},  64'(out_pred),  64'(predOf(pc)));
    endtask

    // Check the empty-head presentation.
    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_pc"},    64'(out_pc),    64'd0);
        checkOutput({tag, "_inst"},  64'(out_inst),  64'd0);
        checkOutput({tag, "_pred"},  64'(out_pred),  64'd0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst       = 1'b0;
        rdy       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_pred   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        checkEmpty("rst");
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_af", 64'(almost_full), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        tick();

        // Push three entries, then drain them in order
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t1_count", 64'(count), 64'd3);
        checkHead("t1_head", 32'h0);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkHead("t1_pop", 32'(4 * i));
            tick();
        end
        checkEmpty("t1_empty");
        checkOutput("t1_count_end", 64'(count), 64'd0);

        // Fill to DEPTH, watch almost_full, drop an extra push
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h10 + 32'(4 * i), 1'b0);
            checkOutput("t2_count", 64'(count), 64'(i));
            checkOutput("t2_af", 64'(almost_full), (i >= 3) ? 64'd1 : 64'd0);
            checkOutput("t2_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        applyStimulus(1'b1, 32'h20, 1'b0);
        checkOutput("t2_full_count", 64'(count), 64'd4);
        checkOutput("t2_full_af", 64'(almost_full), 64'd1);
        checkOutput("t2_full_in_ready", 64'(in_ready), 64'd0);
        tick();
        checkOutput("t2_drop_count", 64'(count), 64'd4);
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            checkHead("t2_pop", 32'h10 + 32'(4 * i));
            tick();
        end
        checkEmpty("t2_empty");
        checkOutput("t2_count_end", 64'(count), 64'd0);

        // Streaming push and pop across several pointer wraps
        applyStimulus(1'b1, 32'h100, 1'b0);
        tick();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            applyStimulus(1'b1, 32'h104 + 32'(4 * i), 1'b1);
            checkOutput("t3_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
            checkOutput("t3_count", 64'(count), 64'd1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkHead("t3_last", 32'h130);
        tick();
        checkOutput("t3_count_end", 64'(count), 64'd0);

        // Clear wins over simultaneous push and pop at count 2
        applyStimulus(1'b1, 32'h200, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h204, 1'b0);
        tick();
        checkOutput("t4_count_pre", 64'(count), 64'd2);
        clear = 1'b1;
        applyStimulus(1'b1, 32'h208, 1'b1);
        checkOutput("t4_clr_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t4_clr_out_valid", 64'(out_valid), 64'd0);
        tick();
        clear = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4_count", 64'(count), 64'd0);
        checkEmpty("t4_empty");
        checkOutput("t4_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 32'h300, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkHead("t4_after", 32'h300);
        checkOutput("t4_count_after", 64'(count), 64'd1);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("t4_drain", 64'(count), 64'd0);

        // rdy low freezes everything, including clear
        applyStimulus(1'b1, 32'h400, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h404, 1'b0);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clear = (i == 2);
            applyStimulus(1'b1, 32'h408, 1'b1);
            checkOutput("t5_in_ready", 64'(in_ready), 64'd0);
            checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
            checkOutput("t5_out_pc", 64'(out_pc), 64'd0);
            checkOutput("t5_count", 64'(count), 64'd2);
            tick();
        end
        clear = 1'b0;
        rdy   = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkHead("t5_resume", 32'h400);
        checkOutput("t5_count_resume", 64'(count), 64'd2);

        // Asynchronous reset between edges at count 3
        applyStimulus(1'b1, 32'h408, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t6_count_pre", 64'(count), 64'd3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t6_count_rst", 64'(count), 64'd0);
        checkEmpty("t6_rst");
        #1;
        rst = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h40, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkHead("t6_first", 32'h40);
        checkOutput("t6_count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
